// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory_unit between the fetch and data requesters.
// Each access is one IDLE -> ACCESS -> RESP round with a range/size check.
module mem_port_arbiter #(
  parameter int unsigned MEMSIZE      = 524288,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic [63:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [64:0] MEM_TOP = 65'(MEMSIZE);

  state_t      state, state_nxt;
  logic        sel_q;
  logic        we_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  streak;

  logic        any_req;
  logic        grant_data;
  logic [63:0] g_addr;
  logic [1:0]  g_size;
  logic [64:0] g_end;
  logic        g_err;
  logic        mem_active;

  // The end address is formed one bit wider so a wrapped address still fails the check.
  always_comb begin
    any_req    = f_req || d_req;
    grant_data = d_req && !(f_req && streak == LIMIT);
    g_addr     = grant_data ? d_addr : f_addr;
    g_size     = grant_data ? d_size : 2'd2;
    g_end      = {1'b0, g_addr} + ((g_size == 2'd3) ? 65'd8 : 65'd4);
    g_err      = (g_end > MEM_TOP) || (grant_data && !d_size[1]);
  end

  always_comb begin
    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd3;
      addr_q  <= '0;
      wdata_q <= '0;
      streak  <= '0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        sel_q   <= grant_data;
        addr_q  <= g_addr;
        size_q  <= g_size;
        we_q    <= grant_data && d_we;
        wdata_q <= grant_data ? d_wdata : '0;
        err_q   <= g_err;
        if (!grant_data)
          streak <= '0;
        else if (f_req && streak < LIMIT)
          streak <= streak + 4'd1;
      end
      // Writes leave d_rdata holding the last read; a faulted access reports zero.
      if (state == ACCESS) begin
        if (sel_q) begin
          if (err_q)
            d_rdata <= '0;
          else if (!we_q)
            d_rdata <= (size_q == 2'd2) ? {32'd0, mem_rdata[31:0]} : mem_rdata;
        end else begin
          f_rdata <= err_q ? '0 : mem_rdata[31:0];
        end
      end
    end
  end

  assign mem_active   = (state == ACCESS) && !err_q;
  assign mem_addr     = mem_active ? addr_q : '0;
  assign mem_size     = mem_active ? size_q : 2'd3;
  assign mem_read_en  = mem_active && !we_q;
  assign mem_write_en = mem_active && we_q;
  assign mem_wdata    = mem_active ? wdata_q : '0;

  assign busy  = (state != IDLE);
  assign f_ack = (state == RESP) && !sel_q;
  assign d_ack = (state == RESP) && sel_q;
  assign f_err = f_ack && err_q;
  assign d_err = d_ack && err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory_unit stand-in plus a transaction-level
// reference (shadow memory, starvation counter, expected response registers).
module tb_mem_port_arbiter;
  localparam int unsigned MEMSIZE = 524288;
  localparam int unsigned LIMIT   = 2;
  localparam int          AW      = $clog2(MEMSIZE);

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [63:0] f_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        f_ack, f_err, d_ack, d_err, busy;
  logic [31:0] f_rdata;
  logic [63:0] d_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_read_en, mem_write_en;

  bit [7:0]    mem     [MEMSIZE];
  bit [7:0]    ref_mem [MEMSIZE];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  m_streak;
  logic [31:0] exp_f_rdata;
  logic [63:0] exp_d_rdata;

  mem_port_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // memory_unit stand-in: combinational little-endian read, write on the clock edge.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (mem_addr < 64'(MEMSIZE - i))
        mem_rdata[8*i +: 8] = mem[AW'(mem_addr + 64'(i))];
  end

  always @(posedge clk)
    if (mem_write_en)
      for (int i = 0; i < 8; i++)
        if (i < 4 || mem_size == 2'd3)
          mem[AW'(mem_addr + 64'(i))] <= mem_wdata[8*i +: 8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a, input int nb);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[AW'(a + 64'(i))];
    return v;
  endfunction

  function automatic logic [63:0] dut_mem_read(input logic [63:0] a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[AW'(a + 64'(i))];
    return v;
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    if (k == 0) return 64'(MEMSIZE) - 64'($urandom_range(0, 12));
    if (k == 1) return {$urandom, $urandom};
    return 64'($urandom_range(0, 1023));
  endfunction

  task automatic check_idle_mem(input string tag);
    check({tag, "_ren"},   mem_read_en, 0);
    check({tag, "_wen"},   mem_write_en, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_msize"}, mem_size, 3);
    check({tag, "_mwd"},   mem_wdata, 0);
  endtask

  // One arbitration round starting in IDLE with inputs already driven; returns the
  // observed winner (1 = data) so ordering checks compare against DUT behaviour.
  task automatic run_round(output bit won_data);
    bit          dw, we, e;
    int          nb;
    logic [63:0] a, rd;
    logic [1:0]  sz;
    dw = d_req && !(f_req && m_streak == 4'(LIMIT));
    a  = dw ? d_addr : f_addr;
    sz = dw ? d_size : 2'd2;
    we = dw && d_we;
    nb = (sz == 2'd3) ? 8 : 4;
    e  = (dw && sz < 2'd2) || (a > 64'(MEMSIZE) - 64'(nb));
    if (!dw) m_streak = 0;
    else if (f_req && m_streak < 4'(LIMIT)) m_streak = m_streak + 1;
    rd = e ? 64'd0 : ref_read(a, nb);
    if (!e && we)
      for (int i = 0; i < nb; i++) ref_mem[AW'(a + 64'(i))] = d_wdata[8*i +: 8];
    if (dw) begin
      if (e) exp_d_rdata = '0;
      else if (!we) exp_d_rdata = rd;
    end else begin
      exp_f_rdata = rd[31:0];
    end

    @(posedge clk); #1;
    check("acc_busy",  busy, 1);
    check("acc_ren",   mem_read_en, !e && !we);
    check("acc_wen",   mem_write_en, !e && we);
    check("acc_maddr", mem_addr, e ? 64'd0 : a);
    check("acc_msize", mem_size, e ? 2'd3 : sz);
    check("acc_mwd",   mem_wdata, (e || !dw) ? 64'd0 : d_wdata);
    check("acc_acks",  {f_ack, d_ack}, 0);

    @(posedge clk); #1;
    won_data = d_ack;
    check("resp_f_ack",   f_ack, !dw);
    check("resp_d_ack",   d_ack, dw);
    check("resp_f_err",   f_err, !dw && e);
    check("resp_d_err",   d_err, dw && e);
    check("resp_f_rdata", f_rdata, exp_f_rdata);
    check("resp_d_rdata", d_rdata, exp_d_rdata);
    check("resp_busy",    busy, 1);
    check("resp_streak",  dut.streak, m_streak);
    check_idle_mem("resp");
    if (dw) d_req = 0; else f_req = 0;

    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_acks", {f_ack, d_ack}, 0);
    check_idle_mem("idle");
  endtask

  task automatic set_data(input bit we, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] wd);
    d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    bit         won;
    bit [5:0]   order;
    logic [63:0] saved;
    reset = 1; f_req = 0; d_req = 0; d_we = 0; d_size = 2'd2;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    m_streak = 0; exp_f_rdata = '0; exp_d_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_acks", {f_ack, d_ack}, 0);
    check("rst_errs", {f_err, d_err}, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_streak", dut.streak, 0);
    check_idle_mem("rst");
    #2 reset = 0;

    // Fetch of a word written through the data port (bytes 13 57 9B DF)
    set_data(1, 2'd2, 64'h2000, 64'hFFFF_0000_DF9B_5713);
    run_round(won);
    f_req = 1; f_addr = 64'h2000;
    run_round(won);
    check("tp_fetch_word", f_rdata, 64'hDF9B_5713);

    // 64-bit write then 64-bit and 32-bit reads
    set_data(1, 2'd3, 64'h100, 64'h0123_4567_89AB_CDEF);
    run_round(won);
    set_data(0, 2'd3, 64'h100, '0);
    run_round(won);
    check("tp_read64", d_rdata, 64'h0123_4567_89AB_CDEF);
    set_data(0, 2'd2, 64'h100, '0);
    run_round(won);
    check("tp_read32", d_rdata, 64'h0000_0000_89AB_CDEF);

    // Simultaneous requests: data first, fetch three cycles later
    f_req = 1; f_addr = 64'h2000;
    set_data(0, 2'd3, 64'h100, 64'h55);
    run_round(won);
    check("sim_first_data", won, 1);
    run_round(won);
    check("sim_second_fetch", won, 0);

    // Starvation guard with a fetch held pending throughout
    order = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      f_req = 1; f_addr = 64'h2000;
      set_data(0, 2'd3, 64'h100, '0);
      run_round(won);
      check("starve_order", won, order[i]);
    end
    f_req = 0; d_req = 0;

    // Range and size errors
    set_data(0, 2'd3, 64'(MEMSIZE - 4), '0);
    run_round(won);
    set_data(1, 2'd3, 64'(MEMSIZE - 4), 64'hDEAD);
    run_round(won);
    set_data(0, 2'd1, 64'h100, '0);
    run_round(won);
    check("err_size_flag_seen", d_rdata, 0);
    f_req = 1; f_addr = 64'hFFFF_FFFF_FFFF_FFFE;
    run_round(won);
    set_data(0, 2'd2, 64'(MEMSIZE - 4), '0);
    run_round(won);

    // Reset during ACCESS of a write: nothing commits, everything back to reset values
    set_data(1, 2'd3, 64'h200, 64'h1111_2222_3333_4444);
    run_round(won);
    saved = ref_read(64'h200, 8);
    set_data(1, 2'd3, 64'h200, 64'hA5A5_5A5A_DEAD_BEEF);
    @(posedge clk); #1;
    check("mid_wen_pre", mem_write_en, 1);
    reset = 1; #1;
    check("mid_busy", busy, 0);
    check("mid_acks", {f_ack, d_ack}, 0);
    check("mid_f_rdata", f_rdata, 0);
    check("mid_d_rdata", d_rdata, 0);
    check_idle_mem("mid");
    @(posedge clk); #1;
    check("mid_no_ack", d_ack, 0);
    check("mid_mem200", dut_mem_read(64'h200), saved);
    d_req = 0;
    #2 reset = 0;
    m_streak = 0; exp_f_rdata = '0; exp_d_rdata = '0;
    set_data(0, 2'd3, 64'h200, '0);
    run_round(won);
    check("mid_read200", d_rdata, 64'h1111_2222_3333_4444);

    // Randomised traffic; a losing request stays pending with its fields unchanged
    for (int n = 0; n < 150; n++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin
        f_req = 1; f_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        set_data(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                 rand_addr(), {$urandom, $urandom});
      end
      if (!f_req && !d_req) begin
        f_req = 1; f_addr = rand_addr();
      end
      run_round(won);
    end
    f_req = 0; d_req = 0;
    for (int i = 0; i < 16; i++)
      check("final_mem", dut_mem_read(64'(64 * i)), ref_read(64'(64 * i), 8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the single-ported byte-addressable `memory_unit` inside the Tinker core. It shares the memory between the instruction-fetch requester and the data requester (load/store/call/return). It serialises their accesses through a req/ack handshake, range-checks each access, and captures read data into per-port response registers. It drives the `memory_unit` address, size, enable and write-data pins directly.

## Interface
- `MEMSIZE`, 524288: memory size in bytes; must match the instantiated `memory_unit`.
- `STARVE_LIMIT`, 4: number of consecutive data grants with fetch pending, after which fetch wins the next arbitration (range 1–15).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `f_req` in 1: fetch request; held until `f_ack`.
- `f_addr` in 64: fetch byte address; access is always 32-bit.
- `f_ack` out 1: one-cycle fetch completion pulse.
- `f_rdata` out 32: fetched word; valid while `f_ack`=1 and held until the next fetch completion.
- `f_err` out 1: range error; valid with `f_ack`.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_size` in 2: 2 = 32-bit, 3 = 64-bit; other codes are illegal.
- `d_addr` in 64: data byte address.
- `d_wdata` in 64: write data; for size 2 only bits [31:0] are meaningful.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_rdata` out 64: read data, zero-extended for size 2; valid with `d_ack` and held.
- `d_err` out 1: range error or illegal size; valid with `d_ack`.
- `mem_addr` out 64, `mem_size` out 2, `mem_read_en` out 1, `mem_write_en` out 1, `mem_wdata` out 64: to `memory_unit`.
- `mem_rdata` in 64: combinational read data from `memory_unit`.
- `busy` out 1: high in ACCESS and RESP.

## Operation
- States: IDLE, ACCESS, RESP. Transitions: IDLE→ACCESS when any request is pending; ACCESS→RESP always; RESP→IDLE always.
- Arbitration happens only in IDLE, at the clock edge:
  - Only one request pending: that request wins.
  - Both pending: data wins, unless `streak`==`STARVE_LIMIT`, in which case fetch wins.
- Grant edge latches `sel` (0 = fetch, 1 = data), addr, size (2 for fetch), we (0 for fetch), wdata and err into internal registers. Requester inputs are not used again until the next IDLE.
- err = (addr + bytes > `MEMSIZE`) or (data port and size ∉ {2,3}). Bytes is 4 or 8. The sum is computed 65-bit so a wrapped address is flagged.
- `streak` (4-bit): +1 on each data grant while `f_req`=1; cleared on a fetch grant and on reset; saturates at `STARVE_LIMIT`.
- ACCESS without err:
  - `mem_addr`/`mem_size` come from the latched registers.
  - `mem_read_en` = !we.
  - `mem_write_en` = we.
  - `mem_wdata` = latched wdata.
  - Read data is captured at the ACCESS→RESP edge into `f_rdata` ([31:0]) or `d_rdata` according to `sel`.
  - The write commits at that same edge.
- ACCESS with err: no enable is asserted. Rdata for the selected port is set to 0.
- RESP: the ack of the selected port is high for exactly one cycle; its err output equals the latched err.
- Outside ACCESS: `mem_read_en`=`mem_write_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_size`=3.
- The requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.

## Timing
- Reset values: state IDLE; `f_ack`=`d_ack`=`f_err`=`d_err`=0; `f_rdata`=0; `d_rdata`=0; `busy`=0; mem outputs at their idle values; `streak`=0.
- Latency: req high in IDLE cycle N → ACCESS in N+1 → ack in N+2 → IDLE in N+3.
- Throughput: one access per 3 cycles.
- Simultaneous requests (data wins): `d_ack` at N+2, `f_ack` at N+5.
- Fetch pending continuously with data re-requesting every IDLE: fetch is granted at the latest on the (`STARVE_LIMIT`+1)-th arbitration.
- Reset mid-ACCESS or mid-RESP:
  - Immediate return to IDLE.
  - Any pending ack is lost.
  - No write commits unless the edge was already taken.
  - Requesters re-issue after reset.
- `f_ack` and `d_ack` are never high in the same cycle.

## Test plan
- Memory bytes 0x2000..0x2003 = 13 57 9B DF; `f_req` with `f_addr`=0x2000 at cycle N → `f_ack`=1 at N+2, `f_rdata`=0xDF9B5713, `f_err`=0.
- Data write: `d_we`=1, size 3, addr 0x100, wdata 0x0123456789ABCDEF → `d_ack` at N+2. Then read size 3 → `d_rdata`=0x0123456789ABCDEF. Then read size 2 → `d_rdata`=0x0000000089ABCDEF.
- `f_req` and `d_req` both rise at N → `d_ack` at N+2 and `f_ack` at N+5; `mem_read_en` high only in N+1 and N+4.
- `STARVE_LIMIT`=2, `f_req` held high, `d_req` re-asserted each IDLE → grant order is D, D, F, D, D, F; `streak` is back at 0 after each F.
- Range/size errors, each giving ack with err=1, rdata=0, and no mem enable asserted:
  - `d_addr`=`MEMSIZE`-4 with size 3.
  - `d_size`=1.
  - `f_addr`=0xFFFFFFFFFFFFFFFE.
- `reset` pulsed during ACCESS of a write to 0x200 → no `d_ack`, state IDLE, location 0x200 unchanged, all outputs at their reset values.
